// File: rtl/iob_plic_irq_cond_pkg.sv
// Shared configuration for the PLIC interrupt-source conditioner: default
// sizes, legal synchroniser range and the reset hold-off length.
package iob_plic_irq_cond_pkg;

    localparam int unsigned DEF_SOURCES     = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILTER_W    = 4;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Hold-off covers the synchroniser plus the norm register so the first
    // loaded stable state reflects the real pin level.
    function automatic int unsigned holdoff_len(input int unsigned sync_stages);
        return sync_stages + 32'd1;
    endfunction

    function automatic logic conf_legal(input int unsigned sync_stages,
                                        input int unsigned filter_w);
        return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
               (filter_w >= 32'd1);
    endfunction

endpackage

// File: rtl/iob_plic_irq_filter.sv
// Single interrupt source: synchroniser, polarity, stability filter and the
// clean level / rise pulse / sticky glitch outputs.
module iob_plic_irq_filter
    import iob_plic_irq_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_W    = DEF_FILTER_W
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                irq_raw_i,
    input  logic                pol_i,
    input  logic                filt_en_i,
    input  logic [FILTER_W-1:0] filt_len_i,
    input  logic                glitch_clr_i,
    input  logic                load_i,
    input  logic                run_i,
    output logic                src_o,
    output logic                rise_o,
    output logic                glitch_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   norm_r;
    logic                   state_r;
    logic                   state_d_r;
    logic [FILTER_W-1:0]    cnt_r;
    logic                   rise_r;
    logic                   glitch_r;

    logic                   norm_next_s;
    logic [FILTER_W-1:0]    eff_len_s;
    logic [FILTER_W-1:0]    limit_s;
    logic                   state_next_s;
    logic [FILTER_W-1:0]    cnt_next_s;
    logic                   glitch_set_s;

    assign norm_next_s = sync_r[SYNC_STAGES-1] ^ pol_i;

    // Effective filter length: bypass or zero length collapses to one sample.
    always_comb begin
        if (!filt_en_i || (filt_len_i == {FILTER_W{1'b0}})) begin
            eff_len_s = FILTER_W'(1);
        end else begin
            eff_len_s = filt_len_i;
        end
    end

    assign limit_s = eff_len_s - FILTER_W'(1);

    // Stability filter next-state; >= lets a shortened length accept at once.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        glitch_set_s = 1'b0;
        if (load_i) begin
            state_next_s = norm_next_s;
            cnt_next_s   = {FILTER_W{1'b0}};
        end else if (run_i) begin
            if (norm_r == state_r) begin
                cnt_next_s   = {FILTER_W{1'b0}};
                glitch_set_s = (cnt_r != {FILTER_W{1'b0}});
            end else if (cnt_r >= limit_s) begin
                state_next_s = norm_r;
                cnt_next_s   = {FILTER_W{1'b0}};
            end else begin
                cnt_next_s   = cnt_r + FILTER_W'(1);
            end
        end else begin
            cnt_next_s = {FILTER_W{1'b0}};
        end
    end

    // Synchroniser, polarity register and filter state.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            norm_r    <= 1'b0;
            state_r   <= 1'b0;
            state_d_r <= 1'b0;
            cnt_r     <= {FILTER_W{1'b0}};
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], irq_raw_i};
            norm_r    <= norm_next_s;
            state_r   <= state_next_s;
            // The load edge primes the delayed copy so no rise is seen afterwards.
            state_d_r <= load_i ? norm_next_s : state_r;
            cnt_r     <= cnt_next_s;
        end
    end

    // Rise pulse and sticky glitch flag; a new glitch beats a clear strobe.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rise_r   <= 1'b0;
            glitch_r <= 1'b0;
        end else begin
            rise_r   <= run_i & state_r & ~state_d_r;
            glitch_r <= run_i & ((glitch_r & ~glitch_clr_i) | glitch_set_s);
        end
    end

    assign src_o    = state_r;
    assign rise_o   = rise_r;
    assign glitch_o = glitch_r;

endmodule

// File: rtl/iob_plic_irq_cond.sv
// Interrupt-source conditioner in front of the PLIC: reset hold-off and one
// filter instance per source.
module iob_plic_irq_cond
    import iob_plic_irq_cond_pkg::*;
#(
    parameter int unsigned SOURCES     = DEF_SOURCES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_W    = DEF_FILTER_W
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic [SOURCES-1:0]  irq_raw_i,
    input  logic [SOURCES-1:0]  pol_i,
    input  logic [SOURCES-1:0]  filt_en_i,
    input  logic [FILTER_W-1:0] filt_len_i,
    input  logic [SOURCES-1:0]  glitch_clr_i,
    output logic [SOURCES-1:0]  src_o,
    output logic [SOURCES-1:0]  rise_o,
    output logic [SOURCES-1:0]  glitch_o,
    output logic                ready_o
);

    localparam int unsigned HOLDOFF = holdoff_len(SYNC_STAGES);
    localparam int unsigned HO_W    = $clog2(HOLDOFF + 1);

    if (!conf_legal(SYNC_STAGES, FILTER_W)) begin : g_bad_conf
        $error("iob_plic_irq_cond: SYNC_STAGES must be 2..4 and FILTER_W >= 1");
    end

    logic [HO_W-1:0] holdoff_cnt_r;
    logic            ready_r;
    logic            load_s;

    assign load_s = ~ready_r & (holdoff_cnt_r == HO_W'(HOLDOFF - 1));

    // Hold-off counter; ready latches on the load edge until the next reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            holdoff_cnt_r <= {HO_W{1'b0}};
            ready_r       <= 1'b0;
        end else if (!ready_r) begin
            if (load_s) begin
                ready_r <= 1'b1;
            end else begin
                holdoff_cnt_r <= holdoff_cnt_r + HO_W'(1);
            end
        end
    end

    assign ready_o = ready_r;

    for (genvar i = 0; i < SOURCES; i++) begin : g_src
        iob_plic_irq_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
        ) u_filter (
            .clk_i        (clk_i),
            .arst_n_i     (arst_n_i),
            .irq_raw_i    (irq_raw_i[i]),
            .pol_i        (pol_i[i]),
            .filt_en_i    (filt_en_i[i]),
            .filt_len_i   (filt_len_i),
            .glitch_clr_i (glitch_clr_i[i]),
            .load_i       (load_s),
            .run_i        (ready_r),
            .src_o        (src_o[i]),
            .rise_o       (rise_o[i]),
            .glitch_o     (glitch_o[i])
        );
    end

endmodule

// File: tb/tb_iob_plic_irq_cond.sv
// Directed bench for iob_plic_irq_cond with hand-computed expected values.
module tb_iob_plic_irq_cond;

    logic       clk;
    logic       arst_n;
    logic [7:0] irq_raw;
    logic [7:0] pol;
    logic [7:0] filt_en;
    logic [3:0] filt_len;
    logic [7:0] glitch_clr;
    logic [7:0] src;
    logic [7:0] rise;
    logic [7:0] glitch;
    logic       ready;

    int n_vec;
    int n_miscmp;

    iob_plic_irq_cond dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .irq_raw_i    (irq_raw),
        .pol_i        (pol),
        .filt_en_i    (filt_en),
        .filt_len_i   (filt_len),
        .glitch_clr_i (glitch_clr),
        .src_o        (src),
        .rise_o       (rise),
        .glitch_o     (glitch),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_miscmp   = 0;
        arst_n     = 1'b0;
        irq_raw    = 8'h01;
        pol        = 8'h01;
        filt_en    = 8'h00;
        filt_len   = 4'd0;
        glitch_clr = 8'h00;

        // Reset state and hold-off with an idle-high active-low line.
        tick(3);
        check_vec("rst_src", 32'(src), 32'h00);
        check_vec("rst_ready", 32'(ready), 32'h0);
        check_vec("rst_glitch", 32'(glitch), 32'h00);
        arst_n = 1'b1;
        tick(1);
        check_vec("ho_ready_e1", 32'(ready), 32'h0);
        tick(1);
        check_vec("ho_ready_e2", 32'(ready), 32'h0);
        tick(1);
        check_vec("ho_ready_e3", 32'(ready), 32'h1);
        check_vec("ho_src_e3", 32'(src), 32'h00);
        tick(1);
        check_vec("ho_src_e4", 32'(src), 32'h00);
        check_vec("ho_rise_e4", 32'(rise), 32'h00);
        tick(1);
        check_vec("ho_rise_e5", 32'(rise), 32'h00);
        check_vec("ho_glitch", 32'(glitch), 32'h00);

        // Filter off: raw[2] rise reaches src after 4 edges, rise one later.
        irq_raw = 8'h05;
        tick(3);
        check_vec("nf_src_e3", 32'(src), 32'h00);
        tick(1);
        check_vec("nf_src_e4", 32'(src), 32'h04);
        check_vec("nf_rise_e4", 32'(rise), 32'h00);
        tick(1);
        check_vec("nf_rise_e5", 32'(rise), 32'h04);
        tick(1);
        check_vec("nf_rise_e6", 32'(rise), 32'h00);

        // L=5, raw[3] high for 3 cycles only: rejected, glitch flagged.
        filt_en  = 8'h08;
        filt_len = 4'd5;
        irq_raw  = 8'h0D;
        tick(3);
        irq_raw  = 8'h05;
        tick(3);
        check_vec("gl_pre_e6", 32'(glitch), 32'h00);
        tick(1);
        check_vec("gl_set_e7", 32'(glitch), 32'h08);
        tick(3);
        check_vec("gl_src", 32'(src), 32'h04);
        glitch_clr = 8'h08;
        tick(1);
        glitch_clr = 8'h00;
        check_vec("gl_clr", 32'(glitch), 32'h00);

        // Held high: accepted after 2+1+5 = 8 edges.
        irq_raw = 8'h0D;
        tick(7);
        check_vec("acc_src_e7", 32'(src), 32'h04);
        tick(1);
        check_vec("acc_src_e8", 32'(src), 32'h0C);
        tick(1);
        check_vec("acc_rise_e9", 32'(rise), 32'h08);

        // Two-sample dropout on src 3 with clear strobe on the glitch edge.
        irq_raw = 8'h05;
        tick(2);
        irq_raw = 8'h0D;
        tick(3);
        check_vec("gc_pre_e5", 32'(glitch), 32'h00);
        glitch_clr = 8'h08;
        tick(1);
        glitch_clr = 8'h00;
        check_vec("gc_set_wins", 32'(glitch), 32'h08);
        check_vec("gc_src", 32'(src), 32'h0C);
        glitch_clr = 8'h08;
        tick(1);
        glitch_clr = 8'h00;
        check_vec("gc_clr", 32'(glitch), 32'h00);

        // L=10 with count at 7, then length cut to 4: immediate accept.
        filt_en  = 8'h18;
        filt_len = 4'd10;
        irq_raw  = 8'h1D;
        tick(10);
        check_vec("shr_src_c7", 32'(src), 32'h0C);
        filt_len = 4'd4;
        tick(1);
        check_vec("shr_src_acc", 32'(src), 32'h1C);

        // All sources high, then async reset while counters are mid-count.
        filt_en = 8'h00;
        pol     = 8'h00;
        irq_raw = 8'hFF;
        tick(4);
        check_vec("all_src", 32'(src), 32'hFF);
        filt_en  = 8'hFF;
        filt_len = 4'd10;
        irq_raw  = 8'h00;
        tick(4);
        #2;
        arst_n = 1'b0;
        #1;
        check_vec("arst_src", 32'(src), 32'h00);
        check_vec("arst_ready", 32'(ready), 32'h0);
        check_vec("arst_rise_gl", 32'({rise, glitch}), 32'h0000);
        tick(2);
        arst_n = 1'b1;
        tick(2);
        check_vec("ho2_ready_e2", 32'(ready), 32'h0);
        tick(1);
        check_vec("ho2_ready_e3", 32'(ready), 32'h1);
        check_vec("ho2_src", 32'(src), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
